// File: rtl/cache_arb_pkg.sv
// Shared types and requester indices for the cache-to-memory arbiter.
// Pure declarations; no logic.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

endpackage

// File: rtl/cache_arb_rr.sv
// Combinational 2-way round-robin pick: on a tie the requester not served last wins.
// Zero latency; no backpressure, the caller decides when to consume the pick.
module cache_arb_rr
    import cache_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt_onehot,
    output logic       winner
);

    always_comb begin
        winner     = REQ_ICACHE;
        gnt_onehot = '0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[REQ_DCACHE]) begin
            winner = REQ_DCACHE;
        end
        if (|req) begin
            gnt_onehot[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache (0) and D-cache (1); one word per transaction.
// Request-to-done >= 2 edges; requests arriving while busy wait until the next IDLE.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int width = 32,
    parameter int n_req = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [n_req-1:0]            req_i,
    input  logic [n_req-1:0]            we_i,
    input  logic [n_req-1:0][width-1:0] addr_i,
    input  logic [n_req-1:0][width-1:0] wdata_i,
    output logic [n_req-1:0]            gnt_o,
    output logic [n_req-1:0]            done_o,
    output logic [width-1:0]            rdata_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [width-1:0]            mem_addr_o,
    output logic [width-1:0]            mem_wdata_o,
    input  logic [width-1:0]            mem_rdata_i,
    input  logic                        mem_ready_i
);

    arb_state_t              state_q, state_d;
    logic [n_req-1:0]        gnt_q;
    logic                    winner_q;
    logic                    last_q;
    logic                    we_q;
    logic [width-1:0]        addr_q;
    logic [width-1:0]        wdata_q;
    logic [width-1:0]        rdata_q;

    logic [n_req-1:0]        pick_onehot;
    logic                    pick_idx;

    cache_arb_rr u_rr (
        .req        (req_i),
        .last       (last_q),
        .gnt_onehot (pick_onehot),
        .winner     (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_i) state_d = BUSY;
            BUSY:    if (mem_ready_i) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            winner_q <= 1'b0;
            last_q   <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    // Latch the winner's command so live addr_i changes cannot leak onto the bus.
                    if (|req_i) begin
                        gnt_q    <= pick_onehot;
                        winner_q <= pick_idx;
                        we_q     <= we_i[pick_idx];
                        addr_q   <= addr_i[pick_idx];
                        wdata_q  <= wdata_i[pick_idx];
                    end
                end
                BUSY: begin
                    if (mem_ready_i) begin
                        rdata_q <= we_q ? '0 : mem_rdata_i;
                        last_q  <= winner_q;
                    end
                end
                DONE:    gnt_q <= '0;
                default: gnt_q <= '0;
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = (state_q == DONE) ? gnt_q : '0;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = (state_q == BUSY);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: stimulus pushes expected completions, a negedge monitor pops and checks them.
module tb_cache_mem_arbiter;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [1:0]       req_i;
    logic [1:0]       we_i;
    logic [1:0][31:0] addr_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0]       gnt_o;
    logic [1:0]       done_o;
    logic [31:0]      rdata_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic [31:0]      mem_rdata_i;
    logic             mem_ready_i;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    cache_mem_arbiter #(.width(32), .n_req(2)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ready_i (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [1:0] oh(input int idx);
        return (idx == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic issue(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd_exp);
        exp_t e;
        e.done  = oh(idx);
        e.rdata = we ? 32'h0 : rd_exp;
        exp_q.push_back(e);
        req_i[idx]   = 1'b1;
        we_i[idx]    = we;
        addr_i[idx]  = addr;
        wdata_i[idx] = wdata;
    endtask

    // Acts as memory and requester: waits for the grant, checks the bus, completes after lat cycles.
    task automatic serve(input int idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rd,
                         input bit bump, output int edges);
        edges = 0;
        while (gnt_o == 2'b00 && edges < 20) begin
            tick();
            edges++;
        end
        if (gnt_o == 2'b00) begin
            chk("gnt_timeout", {30'h0, gnt_o}, {30'h0, oh(idx)});
            req_i[idx] = 1'b0;
            return;
        end
        chk("gnt", {30'h0, gnt_o}, {30'h0, oh(idx)});
        chk("mem_req_busy", {31'h0, mem_req_o}, 32'h1);
        if (bump) addr_i[idx] = ~addr;
        for (int c = 1; c <= lat; c++) begin
            chk("mem_addr", mem_addr_o, addr);
            chk("mem_we", {31'h0, mem_we_o}, {31'h0, we});
            if (we) chk("mem_wdata", mem_wdata_o, wdata);
            mem_ready_i = (c == lat);
            mem_rdata_i = (c == lat) ? rd : 32'hBAD0_BAD0;
            tick();
            edges++;
        end
        mem_ready_i = 1'b0;
        chk("done_timing", {30'h0, done_o}, {30'h0, oh(idx)});
        chk("mem_req_done", {31'h0, mem_req_o}, 32'h0);
        req_i[idx] = 1'b0;
        we_i[idx]  = 1'b0;
        tick();
    endtask

    always @(negedge clk_i) begin
        if (done_o != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {30'h0, done_o}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_done", {30'h0, done_o}, {30'h0, e.done});
                chk("sb_rdata", rdata_o, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vectors, miscompares);
        $fatal(1);
    end

    initial begin
        int e;
        rst_n_i     = 1'b0;
        req_i       = '0;
        we_i        = '0;
        addr_i      = '0;
        wdata_i     = '0;
        mem_rdata_i = '0;
        mem_ready_i = 1'b1;
        tick();
        tick();
        chk("rst_gnt", {30'h0, gnt_o}, 32'h0);
        chk("rst_done", {30'h0, done_o}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        rst_n_i = 1'b1;
        tick();
        chk("idle_ready_ignored_req", {31'h0, mem_req_o}, 32'h0);
        chk("idle_ready_ignored_done", {30'h0, done_o}, 32'h0);
        mem_ready_i = 1'b0;

        // First tie after reset goes to the D-cache, then the I-cache, and alternates again.
        issue(1, 1'b0, 32'h0000_0A00, 32'h0, 32'hD000_0001);
        issue(0, 1'b0, 32'h0000_0B00, 32'h0, 32'h1000_0001);
        serve(1, 1'b0, 32'h0000_0A00, 32'h0, 1, 32'hD000_0001, 1'b0, e);
        serve(0, 1'b0, 32'h0000_0B00, 32'h0, 1, 32'h1000_0001, 1'b0, e);
        issue(1, 1'b0, 32'h0000_0A04, 32'h0, 32'hD000_0002);
        issue(0, 1'b0, 32'h0000_0B04, 32'h0, 32'h1000_0002);
        serve(1, 1'b0, 32'h0000_0A04, 32'h0, 2, 32'hD000_0002, 1'b0, e);
        serve(0, 1'b0, 32'h0000_0B04, 32'h0, 1, 32'h1000_0002, 1'b0, e);

        issue(0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
        serve(0, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hDEAD_BEEF, 1'b0, e);
        chk("read_latency_edges", e, 2);

        issue(1, 1'b1, 32'h0000_0040, 32'h0000_1234, 32'h0);
        serve(1, 1'b1, 32'h0000_0040, 32'h0000_1234, 3, 32'hFFFF_FFFF, 1'b0, e);
        chk("write_latency_edges", e, 4);

        issue(0, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D);
        serve(0, 1'b0, 32'h0000_0300, 32'h0, 2, 32'hCAFE_F00D, 1'b1, e);

        issue(1, 1'b0, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE);
        serve(1, 1'b0, 32'h0000_0500, 32'h0, 1, 32'h0BAD_CAFE, 1'b0, e);

        // Abandon an in-flight I-cache read; the pointer must return to its reset value.
        req_i[0]  = 1'b1;
        we_i[0]   = 1'b0;
        addr_i[0] = 32'h0000_0200;
        tick();
        tick();
        chk("pre_rst_mem_req", {31'h0, mem_req_o}, 32'h1);
        chk("pre_rst_mem_addr", mem_addr_o, 32'h0000_0200);
        rst_n_i     = 1'b0;
        req_i       = '0;
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h5555_5555;
        tick();
        chk("midrst_gnt", {30'h0, gnt_o}, 32'h0);
        chk("midrst_done", {30'h0, done_o}, 32'h0);
        chk("midrst_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("midrst_mem_addr", mem_addr_o, 32'h0);
        chk("midrst_rdata", rdata_o, 32'h0);
        rst_n_i = 1'b1;
        tick();
        chk("post_rst_done", {30'h0, done_o}, 32'h0);
        chk("post_rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        mem_ready_i = 1'b0;

        issue(1, 1'b0, 32'h0000_0A08, 32'h0, 32'hD000_0003);
        issue(0, 1'b0, 32'h0000_0B08, 32'h0, 32'h1000_0003);
        serve(1, 1'b0, 32'h0000_0A08, 32'h0, 1, 32'hD000_0003, 1'b0, e);
        serve(0, 1'b0, 32'h0000_0B08, 32'h0, 1, 32'h1000_0003, 1'b0, e);

        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
